// File: rtl/bt656_trs_decoder_if.sv
// ---------------------------------------------------------------------------
// bt656_trs_decoder_if
// Pixel-bus bundle between the ADV7280A capture registers, the TRS decoder
// and the video frontend / control CPU.
//
// Flow control: none. One byte enters on P_DATA_i every PCLK_i cycle and one
// byte leaves on P_DATA_o every cycle, two cycles later. There is no valid,
// no ready and no stall; every status output is a plain level or a
// single-cycle pulse.
//
// master : pixel source / downstream consumer side (drives P_DATA_i).
// slave  : the decoder (drives everything else).
// fsm_state_o exposes the preamble FSM state for observation.
// ---------------------------------------------------------------------------
interface bt656_trs_decoder_if;
    logic [7:0]  P_DATA_i;
    logic [7:0]  P_DATA_o;
    logic        HS_o;
    logic        VS_o;
    logic        FID_o;
    logic        trs_err_o;
    logic        trs_corr_o;
    logic [15:0] err_cnt_o;
    logic [11:0] line_len_o;
    logic        sync_lock_o;
    logic [1:0]  fsm_state_o;

    modport master (
        output P_DATA_i,
        input  P_DATA_o, HS_o, VS_o, FID_o, trs_err_o, trs_corr_o,
        input  err_cnt_o, line_len_o, sync_lock_o, fsm_state_o
    );

    modport slave (
        input  P_DATA_i,
        output P_DATA_o, HS_o, VS_o, FID_o, trs_err_o, trs_corr_o,
        output err_cnt_o, line_len_o, sync_lock_o, fsm_state_o
    );
endinterface

// File: rtl/bt656_trs_decoder.sv
// ---------------------------------------------------------------------------
// bt656_trs_decoder
// Finds BT.656 timing reference sequences (FF 00 00 XY) in the 8-bit pixel
// stream, checks the XY protection bits, regenerates HS/VS/FID and delays
// the data by two cycles so XY sits on P_DATA_o one cycle before HS rises.
// Also measures line length, tracks line-timing lock and counts bad XYs.
//
// Optional feature macro: TRS_ECC_EN
//   defined   -> XY codes one bit away from a valid code are corrected.
//   undefined -> only exact codes are accepted; trs_corr_o stays 0.
//
// Pipeline (XY sampled at cycle n):
//   n+1 : decode registered (stage 1)
//   n+2 : XY (possibly corrected) on P_DATA_o (stage 2)
//   n+3 : HS/VS/FID/trs_err/trs_corr/line_len (stage 3)
//   n+4 : sync_lock/err_cnt (stage 4)
// ---------------------------------------------------------------------------
module bt656_trs_decoder #(
    parameter int LOCK_LINES = 4
) (
    input  logic               PCLK_i,
    input  logic               reset_n,
    bt656_trs_decoder_if.slave bus
);

    localparam logic [3:0]  LOCK_N   = 4'(LOCK_LINES);
    localparam logic [11:0] LINE_MAX = 12'hFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S_FF = 2'd1,
        S_Z1 = 2'd2,
        S_Z2 = 2'd3
    } trs_state_t;

    trs_state_t state;

    // Valid XY for a given F/V/H: bit7 set, then F V H, then P3..P0.
    function automatic logic [7:0] trs_code(input logic f, input logic v, input logic h);
        return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

`ifdef TRS_ECC_EN
    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, x[i]};
        end
        return n;
    endfunction

    logic [7:0] cand;
    logic [3:0] dist;
    logic [2:0] fvh;
`endif

    // Combinational classification of the current byte as an XY code.
    logic [7:0] xy_code;
    logic       xy_ok;
    logic       xy_fix;

    // Stage 1 registers.
    logic [7:0] s1_data;
    logic [7:0] s1_code;
    logic       s1_xy;
    logic       s1_ok;
    logic       s1_fix;

    // Stage 2 event flags.
    logic       s2_acc;
    logic       s2_rej;
    logic       s2_fix;
    logic       s2_f;
    logic       s2_v;
    logic       s2_h;

    // Stage 3 bookkeeping.
    logic [11:0] line_cnt;
    logic        hs_pending;
    logic        eav3;
    logic        match3;

    // Stage 4 lock tracking.
    logic [3:0] match_cnt;
    logic [3:0] match_inc;

    assign bus.fsm_state_o = state;
    assign match_inc       = (match_cnt == 4'hF) ? 4'hF : match_cnt + 4'd1;

    // Classify the incoming byte as an acceptable XY and pick its (corrected) code.
    always_comb begin
        xy_code = bus.P_DATA_i;
        xy_ok   = 1'b0;
        xy_fix  = 1'b0;
`ifdef TRS_ECC_EN
        cand = 8'h00;
        dist = 4'd0;
        fvh  = 3'd0;
        // Valid codes are 4 apart, so at most one candidate can be within 1 bit.
        for (int i = 0; i < 8; i++) begin
            fvh  = 3'(i);
            cand = trs_code(fvh[2], fvh[1], fvh[0]);
            dist = popcount8(bus.P_DATA_i ^ cand);
            if (dist == 4'd0) begin
                xy_ok   = 1'b1;
                xy_code = cand;
            end else if (dist == 4'd1) begin
                xy_ok   = 1'b1;
                xy_fix  = 1'b1;
                xy_code = cand;
            end
        end
`else
        xy_ok = (bus.P_DATA_i == trs_code(bus.P_DATA_i[6], bus.P_DATA_i[5], bus.P_DATA_i[4]));
`endif
    end

    // Preamble FSM: one transition per byte, S_Z2 marks the XY byte.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: state <= (bus.P_DATA_i == 8'hFF) ? S_FF : IDLE;
                S_FF: begin
                    if (bus.P_DATA_i == 8'h00)      state <= S_Z1;
                    else if (bus.P_DATA_i == 8'hFF) state <= S_FF;
                    else                            state <= IDLE;
                end
                S_Z1: begin
                    if (bus.P_DATA_i == 8'h00)      state <= S_Z2;
                    else if (bus.P_DATA_i == 8'hFF) state <= S_FF;
                    else                            state <= IDLE;
                end
                S_Z2: state <= (bus.P_DATA_i == 8'hFF) ? S_FF : IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1: capture the byte and its XY decode.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            s1_data <= 8'h00;
            s1_code <= 8'h00;
            s1_xy   <= 1'b0;
            s1_ok   <= 1'b0;
            s1_fix  <= 1'b0;
        end else begin
            s1_data <= bus.P_DATA_i;
            s1_code <= xy_code;
            s1_xy   <= (state == S_Z2);
            s1_ok   <= xy_ok;
            s1_fix  <= xy_fix;
        end
    end

    // Stage 2: data output (corrected XY substituted) and TRS event flags.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            bus.P_DATA_o <= 8'h00;
            s2_acc       <= 1'b0;
            s2_rej       <= 1'b0;
            s2_fix       <= 1'b0;
            s2_f         <= 1'b0;
            s2_v         <= 1'b0;
            s2_h         <= 1'b0;
        end else begin
            bus.P_DATA_o <= (s1_xy && s1_ok && s1_fix) ? s1_code : s1_data;
            s2_acc       <= s1_xy && s1_ok;
            s2_rej       <= s1_xy && !s1_ok;
            s2_fix       <= s1_xy && s1_ok && s1_fix;
            s2_f         <= s1_code[6];
            s2_v         <= s1_code[5];
            s2_h         <= s1_code[4];
        end
    end

    // Stage 3: timing outputs, line counter and per-EAV length comparison.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            bus.HS_o       <= 1'b0;
            bus.VS_o       <= 1'b0;
            bus.FID_o      <= 1'b0;
            bus.trs_err_o  <= 1'b0;
            bus.trs_corr_o <= 1'b0;
            bus.line_len_o <= 12'd0;
            line_cnt       <= 12'd0;
            hs_pending     <= 1'b0;
            eav3           <= 1'b0;
            match3         <= 1'b0;
        end else begin
            bus.trs_err_o  <= s2_rej;
            bus.trs_corr_o <= s2_fix;
            hs_pending     <= 1'b0;
            eav3           <= 1'b0;
            match3         <= 1'b0;
            if (s2_acc && s2_h) begin
                // EAV with HS already high means SAV was lost: force a
                // one-cycle low so the frontend still gets a rising edge.
                if (bus.HS_o) begin
                    bus.HS_o   <= 1'b0;
                    hs_pending <= 1'b1;
                end else begin
                    bus.HS_o <= 1'b1;
                end
                bus.VS_o       <= s2_v;
                bus.FID_o      <= s2_f;
                bus.line_len_o <= line_cnt;
                line_cnt       <= 12'd1;
                eav3           <= 1'b1;
                match3         <= (line_cnt == bus.line_len_o);
            end else begin
                if (s2_acc) begin
                    bus.HS_o <= 1'b0;
                end else if (hs_pending) begin
                    bus.HS_o <= 1'b1;
                end
                line_cnt <= (line_cnt == LINE_MAX) ? LINE_MAX : line_cnt + 12'd1;
            end
        end
    end

    // Stage 4: error counter and lock state.
    always_ff @(posedge PCLK_i or negedge reset_n) begin
        if (!reset_n) begin
            bus.err_cnt_o   <= 16'd0;
            bus.sync_lock_o <= 1'b0;
            match_cnt       <= 4'd0;
        end else begin
            if (bus.trs_err_o && (bus.err_cnt_o != 16'hFFFF)) begin
                bus.err_cnt_o <= bus.err_cnt_o + 16'd1;
            end
            if (line_cnt == LINE_MAX) begin
                // No EAV for a full counter span: the source is gone.
                match_cnt       <= 4'd0;
                bus.sync_lock_o <= 1'b0;
            end else if (eav3) begin
                if (match3) begin
                    match_cnt       <= match_inc;
                    bus.sync_lock_o <= (match_inc >= LOCK_N);
                end else begin
                    match_cnt       <= 4'd0;
                    bus.sync_lock_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bt656_trs_decoder.sv
// ---------------------------------------------------------------------------
// tb_bt656_trs_decoder
// Directed bench for bt656_trs_decoder: one task per scenario, each driving
// a hand-built byte stream and checking outputs at exact cycle offsets from
// the XY byte. Inputs change #1 after a rising edge; outputs are read there.
// ---------------------------------------------------------------------------
module tb_bt656_trs_decoder;

    logic PCLK_i  = 1'b0;
    logic reset_n = 1'b0;

    int checks   = 0;
    int failures = 0;

`ifdef TRS_ECC_EN
    localparam logic [7:0] BAD2 = 8'h9E;
`else
    localparam logic [7:0] BAD2 = 8'h9F;
`endif

    bt656_trs_decoder_if bus ();

    bt656_trs_decoder #(
        .LOCK_LINES(4)
    ) dut (
        .PCLK_i (PCLK_i),
        .reset_n(reset_n),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 PCLK_i = ~PCLK_i;

    // ---------------- driver ----------------
    task automatic tick(input logic [7:0] b);
        bus.P_DATA_i = b;
        @(posedge PCLK_i);
        #1;
    endtask

    // Byte idx of a line: EAV at 0..3, SAV at 272..275, blanking/active filler elsewhere.
    function automatic logic [7:0] line_byte(input int idx, input logic [7:0] eav,
                                             input logic [7:0] sav, input bit has_sav);
        if (idx == 0) return 8'hFF;
        if (idx == 1 || idx == 2) return 8'h00;
        if (idx == 3) return eav;
        if (has_sav && idx == 272) return 8'hFF;
        if (has_sav && (idx == 273 || idx == 274)) return 8'h00;
        if (has_sav && idx == 275) return sav;
        return idx[0] ? 8'h10 : 8'h80;
    endfunction

    task automatic send_line_from(input int start, input int len, input logic [7:0] eav,
                                  input logic [7:0] sav, input bit has_sav);
        for (int i = start; i < len; i++) tick(line_byte(i, eav, sav, has_sav));
    endtask

    task automatic send_line(input int len, input logic [7:0] eav,
                             input logic [7:0] sav, input bit has_sav);
        send_line_from(0, len, eav, sav, has_sav);
    endtask

    task automatic send_filler(input int n);
        for (int i = 0; i < n; i++) tick(i[0] ? 8'h10 : 8'h80);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.P_DATA_i = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge PCLK_i);
        #1;
        checks++;
        if ({bus.P_DATA_o, bus.HS_o, bus.VS_o, bus.FID_o, bus.trs_err_o, bus.trs_corr_o,
             bus.err_cnt_o, bus.line_len_o, bus.sync_lock_o} !== 49'd0) begin
            failures++;
            $display("FAIL reset_outputs: got pdata=%h hs=%b vs=%b fid=%b err=%b corr=%b cnt=%h len=%h lock=%b want all 0",
                     bus.P_DATA_o, bus.HS_o, bus.VS_o, bus.FID_o, bus.trs_err_o, bus.trs_corr_o,
                     bus.err_cnt_o, bus.line_len_o, bus.sync_lock_o);
        end
        checks++;
        if (bus.fsm_state_o !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d want 0", bus.fsm_state_o);
        end
        @(negedge PCLK_i);
        reset_n = 1'b1;
    endtask

    // First line runs from reset: 1711 filler + EAV XY at byte 1715, so the
    // first measured length is already 1716 and lock comes on the 5th EAV.
    task automatic test_ntsc();
        send_filler(1711);
        for (int i = 0; i < 4; i++) tick(line_byte(i, 8'h9D, 8'h80, 1'b1));
        tick(line_byte(4, 8'h9D, 8'h80, 1'b1));
        checks++;
        if (bus.P_DATA_o !== 8'h9D) begin
            failures++;
            $display("FAIL ntsc_xy_on_data: got %h want 9d", bus.P_DATA_o);
        end
        checks++;
        if (bus.HS_o !== 1'b0) begin
            failures++;
            $display("FAIL ntsc_hs_before_edge: got %b want 0", bus.HS_o);
        end
        tick(line_byte(5, 8'h9D, 8'h80, 1'b1));
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL ntsc_hs_rise: got %b want 1", bus.HS_o);
        end
        checks++;
        if (bus.line_len_o !== 12'd1716) begin
            failures++;
            $display("FAIL ntsc_first_len: got %0d want 1716", bus.line_len_o);
        end
        checks++;
        if (bus.P_DATA_o !== 8'h80) begin
            failures++;
            $display("FAIL ntsc_passthrough: got %h want 80", bus.P_DATA_o);
        end
        send_line_from(6, 1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.HS_o !== 1'b0) begin
            failures++;
            $display("FAIL ntsc_hs_after_sav: got %b want 0", bus.HS_o);
        end
        for (int l = 2; l <= 4; l++) send_line(1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b0) begin
            failures++;
            $display("FAIL ntsc_no_lock_eav4: got %b want 0", bus.sync_lock_o);
        end
        send_line(1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b1) begin
            failures++;
            $display("FAIL ntsc_lock_eav5: got %b want 1", bus.sync_lock_o);
        end
        checks++;
        if (bus.line_len_o !== 12'd1716) begin
            failures++;
            $display("FAIL ntsc_len: got %0d want 1716", bus.line_len_o);
        end
        checks++;
        if (bus.err_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL ntsc_err_cnt: got %0d want 0", bus.err_cnt_o);
        end
    endtask

    task automatic test_missing_sav();
        send_line(1716, 8'h9D, 8'h80, 1'b0);
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL nosav_hs_held: got %b want 1", bus.HS_o);
        end
        for (int i = 0; i < 5; i++) tick(line_byte(i, 8'h9D, 8'h80, 1'b1));
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL nosav_hs_n1: got %b want 1", bus.HS_o);
        end
        tick(line_byte(5, 8'h9D, 8'h80, 1'b1));
        checks++;
        if (bus.HS_o !== 1'b0) begin
            failures++;
            $display("FAIL nosav_hs_low_pulse: got %b want 0", bus.HS_o);
        end
        tick(line_byte(6, 8'h9D, 8'h80, 1'b1));
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL nosav_hs_reassert: got %b want 1", bus.HS_o);
        end
        send_line_from(7, 1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b1) begin
            failures++;
            $display("FAIL nosav_lock_kept: got %b want 1", bus.sync_lock_o);
        end
    endtask

    // Short line S then A..F at 1716: A's EAV sees 1715 (drop), B's sees
    // 1716 vs 1715 (no match), C..F give matches 1..4 -> lock after F.
    task automatic test_short_line();
        send_line(1715, 8'h9D, 8'h80, 1'b1);
        send_line(1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b0) begin
            failures++;
            $display("FAIL short_lock_drop: got %b want 0", bus.sync_lock_o);
        end
        checks++;
        if (bus.line_len_o !== 12'd1715) begin
            failures++;
            $display("FAIL short_len: got %0d want 1715", bus.line_len_o);
        end
        for (int l = 0; l < 4; l++) send_line(1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b0) begin
            failures++;
            $display("FAIL short_lock_early: got %b want 0", bus.sync_lock_o);
        end
        send_line(1716, 8'h9D, 8'h80, 1'b1);
        checks++;
        if (bus.sync_lock_o !== 1'b1) begin
            failures++;
            $display("FAIL short_relock: got %b want 1", bus.sync_lock_o);
        end
    endtask

    // Line counter is ~1711 at the end of the last line; it saturates 2384
    // cycles later, so lock is still held after 2300 and gone after 2500.
    task automatic test_timeout();
        send_filler(2300);
        checks++;
        if (bus.sync_lock_o !== 1'b1) begin
            failures++;
            $display("FAIL timeout_early: got %b want 1", bus.sync_lock_o);
        end
        send_filler(200);
        checks++;
        if (bus.sync_lock_o !== 1'b0) begin
            failures++;
            $display("FAIL timeout_unlock: got %b want 0", bus.sync_lock_o);
        end
    endtask

    task automatic test_field();
        send_line(1716, 8'h9D, 8'h80, 1'b1);
        for (int i = 0; i < 5; i++) tick(line_byte(i, 8'hF1, 8'hEC, 1'b1));
        checks++;
        if ({bus.VS_o, bus.FID_o} !== 2'b00) begin
            failures++;
            $display("FAIL field_vs_fid_n1: got %b%b want 00", bus.VS_o, bus.FID_o);
        end
        tick(line_byte(5, 8'hF1, 8'hEC, 1'b1));
        checks++;
        if ({bus.VS_o, bus.FID_o, bus.HS_o} !== 3'b111) begin
            failures++;
            $display("FAIL field_vs_fid_hs: got vs=%b fid=%b hs=%b want 1 1 1", bus.VS_o, bus.FID_o, bus.HS_o);
        end
        send_line_from(6, 1716, 8'hF1, 8'hEC, 1'b1);
        checks++;
        if ({bus.VS_o, bus.FID_o, bus.HS_o} !== 3'b110) begin
            failures++;
            $display("FAIL field_after_sav: got vs=%b fid=%b hs=%b want 1 1 0", bus.VS_o, bus.FID_o, bus.HS_o);
        end
    endtask

    task automatic test_err_2bit();
        for (int i = 0; i < 5; i++) tick(line_byte(i, BAD2, 8'hEC, 1'b1));
        checks++;
        if (bus.P_DATA_o !== BAD2) begin
            failures++;
            $display("FAIL err2_data: got %h want %h", bus.P_DATA_o, BAD2);
        end
        tick(line_byte(5, BAD2, 8'hEC, 1'b1));
        checks++;
        if (bus.trs_err_o !== 1'b1) begin
            failures++;
            $display("FAIL err2_pulse: got %b want 1", bus.trs_err_o);
        end
        checks++;
        if ({bus.HS_o, bus.VS_o, bus.FID_o} !== 3'b011) begin
            failures++;
            $display("FAIL err2_timing_held: got hs=%b vs=%b fid=%b want 0 1 1", bus.HS_o, bus.VS_o, bus.FID_o);
        end
        tick(line_byte(6, BAD2, 8'hEC, 1'b1));
        checks++;
        if (bus.trs_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err2_pulse_width: got %b want 0", bus.trs_err_o);
        end
        checks++;
        if (bus.err_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL err2_cnt: got %0d want 1", bus.err_cnt_o);
        end
        send_line_from(7, 1716, BAD2, 8'hEC, 1'b1);
    endtask

    task automatic test_err_1bit();
        for (int i = 0; i < 5; i++) tick(line_byte(i, 8'h9C, 8'h80, 1'b1));
`ifdef TRS_ECC_EN
        checks++;
        if (bus.P_DATA_o !== 8'h9D) begin
            failures++;
            $display("FAIL err1_corrected_data: got %h want 9d", bus.P_DATA_o);
        end
        tick(line_byte(5, 8'h9C, 8'h80, 1'b1));
        checks++;
        if ({bus.trs_corr_o, bus.trs_err_o, bus.HS_o, bus.VS_o} !== 4'b1010) begin
            failures++;
            $display("FAIL err1_corr: got corr=%b err=%b hs=%b vs=%b want 1 0 1 0",
                     bus.trs_corr_o, bus.trs_err_o, bus.HS_o, bus.VS_o);
        end
        tick(line_byte(6, 8'h9C, 8'h80, 1'b1));
        checks++;
        if ({bus.trs_corr_o, bus.err_cnt_o} !== {1'b0, 16'd1}) begin
            failures++;
            $display("FAIL err1_after: got corr=%b cnt=%0d want 0 1", bus.trs_corr_o, bus.err_cnt_o);
        end
`else
        checks++;
        if (bus.P_DATA_o !== 8'h9C) begin
            failures++;
            $display("FAIL err1_data_unmodified: got %h want 9c", bus.P_DATA_o);
        end
        tick(line_byte(5, 8'h9C, 8'h80, 1'b1));
        checks++;
        if ({bus.trs_err_o, bus.trs_corr_o, bus.HS_o} !== 3'b100) begin
            failures++;
            $display("FAIL err1_reject: got err=%b corr=%b hs=%b want 1 0 0",
                     bus.trs_err_o, bus.trs_corr_o, bus.HS_o);
        end
        tick(line_byte(6, 8'h9C, 8'h80, 1'b1));
        checks++;
        if (bus.err_cnt_o !== 16'd2) begin
            failures++;
            $display("FAIL err1_cnt: got %0d want 2", bus.err_cnt_o);
        end
`endif
        send_line_from(7, 1716, 8'h9C, 8'h80, 1'b1);
    endtask

    task automatic test_preamble();
        tick(8'hFF);
        checks++;
        if (bus.fsm_state_o !== 2'd1) begin
            failures++;
            $display("FAIL pre_state_ff: got %0d want 1", bus.fsm_state_o);
        end
        tick(8'hFF);
        tick(8'h00);
        tick(8'h00);
        checks++;
        if (bus.fsm_state_o !== 2'd3) begin
            failures++;
            $display("FAIL pre_state_z2: got %0d want 3", bus.fsm_state_o);
        end
        tick(8'h9D); tick(8'h10); tick(8'h80);
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_ffff_eav: got %b want 1", bus.HS_o);
        end
        tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'h80); tick(8'h10); tick(8'h80);
        checks++;
        if (bus.HS_o !== 1'b0) begin
            failures++;
            $display("FAIL pre_sav: got %b want 0", bus.HS_o);
        end
        tick(8'hFF); tick(8'h00); tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'h9D);
        tick(8'h10); tick(8'h80);
        checks++;
        if (bus.HS_o !== 1'b1) begin
            failures++;
            $display("FAIL pre_restart_eav: got %b want 1", bus.HS_o);
        end
        tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'h80); tick(8'h10); tick(8'h80);
        tick(8'hFF); tick(8'h00); tick(8'h10); tick(8'h00); tick(8'h00); tick(8'h9D);
        tick(8'h10); tick(8'h80);
        checks++;
        if ({bus.HS_o, bus.trs_err_o} !== 2'b00) begin
            failures++;
            $display("FAIL pre_broken: got hs=%b err=%b want 0 0", bus.HS_o, bus.trs_err_o);
        end
    endtask

    task automatic test_reset_midline();
        tick(8'hFF); tick(8'h00); tick(8'h00); tick(8'hF1);
        send_filler(5);
        checks++;
        if ({bus.HS_o, bus.VS_o, bus.FID_o} !== 3'b111) begin
            failures++;
            $display("FAIL midrst_pre: got hs=%b vs=%b fid=%b want 1 1 1", bus.HS_o, bus.VS_o, bus.FID_o);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.P_DATA_o, bus.HS_o, bus.VS_o, bus.FID_o, bus.trs_err_o, bus.trs_corr_o,
             bus.err_cnt_o, bus.line_len_o, bus.sync_lock_o, bus.fsm_state_o} !== 51'd0) begin
            failures++;
            $display("FAIL midrst_async: got pdata=%h hs=%b vs=%b fid=%b cnt=%h len=%h lock=%b st=%0d want all 0",
                     bus.P_DATA_o, bus.HS_o, bus.VS_o, bus.FID_o, bus.err_cnt_o, bus.line_len_o,
                     bus.sync_lock_o, bus.fsm_state_o);
        end
        repeat (2) @(posedge PCLK_i);
        @(negedge PCLK_i);
        reset_n = 1'b1;
        tick(8'h10);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.P_DATA_i = 8'h00;
        test_reset();
        test_ntsc();
        test_missing_sav();
        test_short_line();
        test_timeout();
        test_field();
        test_err_2bit();
        test_err_1bit();
        test_preamble();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
